// File: rtl/handshake_pkg.sv
// rtl/handshake_pkg.sv - shared types, default widths and byte-swap helper for the memory reader
package handshake_pkg;

    localparam int HS_ADDR_W = 10;
    localparam int HS_DATA_W = 32;
    localparam int HS_LEN_W  = 11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Reverse byte order of a word: byte 0 <-> byte N-1, byte 1 <-> byte N-2, ...
    function automatic logic [HS_DATA_W-1:0] byte_swap(input logic [HS_DATA_W-1:0] w);
        logic [HS_DATA_W-1:0] r;
        r = '0;
        for (int i = 0; i < HS_DATA_W / 8; i++) begin
            r[8*i +: 8] = w[HS_DATA_W-8-8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/handshake_sync_fifo.sv
// rtl/handshake_sync_fifo.sv - show-ahead synchronous FIFO with occupancy count
module handshake_sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] pop_data_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              full_o,
    output logic              empty_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_q, wr_d;
    logic [PTR_W-1:0]  rd_q, rd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              do_push, do_pop;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Head entry drives the output directly; an empty FIFO presents zero.
    assign pop_data_o = empty_o ? '0 : mem_q[rd_q];

    // Pointer and occupancy next-state; simultaneous push and pop keep the count.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) begin
            wr_d = wr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_d = rd_q + PTR_W'(1);
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Pointer and count registers; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage array; contents are don't-care while the entry is not counted.
    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            mem_q[wr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/handshake_mem_reader.sv
// rtl/handshake_mem_reader.sv - descriptor-driven RAM block reader to a valid/ready stream (option: HANDSHAKE_MEM_READER_BYTESWAP_EN)
module handshake_mem_reader
    import handshake_pkg::*;
#(
    parameter int ADDR_W     = HS_ADDR_W,
    parameter int DATA_W     = HS_DATA_W,
    parameter int LEN_W      = HS_LEN_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [LEN_W-1:0]    length,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   mem_address,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_data,
    input  logic                out_ready
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cur_q, cur_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              inflight_q;
    logic              issue;
    logic              pop;
    logic [DATA_W-1:0] push_data;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              credit_ok;

    assign mem_write      = 1'b0;
    assign mem_byteenable = '1;
    assign mem_clken      = 1'b1;
    assign mem_chipselect = issue;
    assign mem_address    = cur_q;

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;

    // Words already buffered plus the one possibly returning from the RAM must leave room.
    assign credit_ok = (fifo_count + CNT_W'(inflight_q)) < CNT_W'(FIFO_DEPTH);

`ifdef HANDSHAKE_MEM_READER_BYTESWAP_EN
    assign push_data = byte_swap(mem_readdata);
`else
    assign push_data = mem_readdata;
`endif

    handshake_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (inflight_q),
        .push_data_i (push_data),
        .pop_i       (pop),
        .pop_data_o  (out_data),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Job sequencing: accept descriptor, issue credited reads, finish after the last pop.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        rem_d   = rem_q;
        issue   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cur_d   = base_addr;
                    rem_d   = length;
                    state_d = (length != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                busy  = 1'b1;
                issue = (rem_q != '0) && credit_ok && !fifo_full;
                if (issue) begin
                    cur_d = cur_q + ADDR_W'(1);
                    rem_d = rem_q - LEN_W'(1);
                end
                if ((rem_q == '0) && !inflight_q &&
                    (fifo_empty || ((fifo_count == CNT_W'(1)) && pop))) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, address/remaining counters and the one-deep read-in-flight flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cur_q      <= '0;
            rem_q      <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            rem_q      <= rem_d;
            inflight_q <= issue;
        end
    end

endmodule

// File: doc/handshake_mem_reader.md
Name: handshake_mem_reader

Overview:
- Avalon-MM read master placed directly upstream of the handshake accelerator datapath. It sits on the second slave port of the 1024x32 on-chip RAM.
- A Nios II-written descriptor (base, length) triggers it to read a contiguous block of words. The words leave in address order on a valid/ready stream.
- The RAM's one-cycle read latency and consumer back-pressure are both absorbed by a small credit-controlled FIFO.

Parameters:
- ADDR_W, 10, word address width; matches the RAM's 1024-word depth.
- DATA_W, 32, word width.
- LEN_W, 11, length field width; a single job covers 0..1024 words.
- FIFO_DEPTH, 4, output buffer entries; must be a power of two and at least 2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  job request; accepted only while busy=0
- base_addr  in  ADDR_W  first word address of the job
- length  in  LEN_W  number of words in the job
- busy  out  1  high from start acceptance until the done pulse
- done  out  1  one-cycle pulse when the job is complete
- mem_address  out  ADDR_W  RAM word address
- mem_chipselect  out  1  RAM read strobe
- mem_write  out  1  tied 0
- mem_byteenable  out  DATA_W/8  tied all-ones
- mem_clken  out  1  tied 1
- mem_readdata  in  DATA_W  RAM read data; valid one cycle after the strobe
- out_valid  out  1  stream data valid
- out_data  out  DATA_W  stream word
- out_ready  in  1  downstream accept

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values: busy=0, done=0, mem_chipselect=0, mem_address=0, out_valid=0, out_data=0. FIFO is emptied and all counters are cleared.
- Reset mid-job: the job is abandoned, no done pulse is generated, and the reader returns to IDLE on the next edge. Any in-flight read data is discarded.
- FSM state IDLE:
  - start=1 with length≠0 → RUN; latches base_addr, length; busy=1.
  - start=1 with length=0 → DONE; no RAM access.
- FSM state RUN:
  - Issue condition: a read issues in a cycle when remaining>0 and (fifo_count + inflight) < FIFO_DEPTH.
  - An issued read asserts mem_chipselect=1 with mem_address=cur.
  - Per issued read: cur increments modulo 2^ADDR_W (1023 wraps to 0) and remaining decrements.
  - When remaining=0 and the last word has been popped by the consumer → DONE.
- FSM state DONE: done=1 for exactly one cycle; busy returns to 0 in the same cycle; next state IDLE.
- start while busy=1 is ignored; no queueing.
- Read latency: a strobe in cycle N captures mem_readdata into the FIFO at the edge ending cycle N+1.
  - inflight is a 1-bit register.
  - Throughput is one word per cycle when out_ready is held 1.
- Earliest data: first out_valid in cycle t+3 after start is accepted in cycle t. That is one cycle for IDLE→RUN, one for the strobe, one for the FIFO write.
- FIFO behaviour:
  - It is show-ahead: out_data is driven from the head entry.
  - out_valid = (fifo_count≠0).
  - A pop occurs when out_valid & out_ready.
  - Simultaneous push and pop leave fifo_count unchanged.
  - The credit rule guarantees a push never meets a full FIFO.
- Stream rule: while out_valid=1 and out_ready=0, out_data holds stable.
- Ordering: words emerge in strictly ascending address order (modulo wrap). There is no duplication and no loss.
- done asserts only after the final word has been accepted downstream.

Optional Feature:
- Macro: HANDSHAKE_MEM_READER_BYTESWAP_EN.
- When defined: each word is byte-reversed on its way into the FIFO, so bytes [7:0]↔[31:24] and [15:8]↔[23:16]. This presents Nios little-endian buffers as big-endian message words for the hash core.
- When undefined: words pass through unchanged, with no extra logic.
- Latency is identical in both builds.

Decomposition:
- Shared package handshake_pkg holds:
  - the FSM state enum (IDLE, RUN, DONE);
  - the ADDR_W/DATA_W/LEN_W default constants;
  - a byte-swap function.
- Sub-module handshake_sync_fifo: a parameterised show-ahead synchronous FIFO with push, pop, count, full and empty. The reader instantiates it once.

Test Plan:
- Single word: base=0x010, length=1, out_ready=1.
  - Exactly one strobe at address 0x010.
  - out_data = RAM[0x010] in cycle t+3.
  - done pulses once; busy falls with it.
- Streaming: base=0x000, length=16, out_ready=1 → 16 words at one word per cycle, contiguous after the first; done after the 16th is accepted.
- Back-pressure: length=8, out_ready toggling 1,0,0,1 repeatedly.
  - (fifo_count + inflight) never exceeds 4.
  - out_data is stable while stalled.
  - All 8 words arrive in order.
- Wrap: base=0x3FE, length=4 → addresses 0x3FE, 0x3FF, 0x000, 0x001 are read in that order.
- Zero length and start while busy:
  - length=0 → done one cycle after start with no strobes.
  - A second start mid-job is ignored.
- Reset mid-job: assert reset after 3 of 10 words → all outputs return to reset values the next cycle, with no done. A new job then completes normally.
- Byte-swap build: RAM word 0x11223344 is read out as 0x44332211.
